// File: rtl/sym_frame_deserializer_pkg.sv
// Shared constants and types for the symbol-to-frame deserializer.
// The frame is packed with beat 0 in the least-significant lane position.
package sym_frame_deserializer_pkg;

  localparam int SYM_W     = 2;
  localparam int NUM_LANES = 4;
  localparam int DROP_W    = 8;
  localparam int CNT_W     = $clog2(NUM_LANES);
  localparam int FRAME_W   = SYM_W * NUM_LANES;
  localparam int ACC_W     = SYM_W * (NUM_LANES - 1);

  localparam logic [CNT_W-1:0] BEAT_FIRST = CNT_W'(0);
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(NUM_LANES - 1);

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    logic [DROP_W-1:0] r;
    if (v == {DROP_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(DROP_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sym_frame_deserializer_frame_hold_reg.sv
// Output holding register: presents one complete frame on four registered lanes
// and keeps it stable until the downstream consumer takes it.
module frame_hold_reg
  import sym_frame_deserializer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               out_ready,
  output logic [SYM_W-1:0]   lane_1,
  output logic [SYM_W-1:0]   lane_2,
  output logic [SYM_W-1:0]   lane_3,
  output logic [SYM_W-1:0]   lane_4,
  output logic               out_valid,
  output logic               stall
);

  hold_state_e        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // State and frame registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HOLD_EMPTY;
      frame_q <= {FRAME_W{1'b0}};
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

  // Next state: a load wins over a transfer so back-to-back frames never bubble
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    case (state_q)
      HOLD_EMPTY: begin
        if (load) begin
          state_d = HOLD_FULL;
          frame_d = frame_in;
        end else begin
          state_d = HOLD_EMPTY;
        end
      end
      HOLD_FULL: begin
        if (load) begin
          state_d = HOLD_FULL;
          frame_d = frame_in;
        end else if (out_ready) begin
          state_d = HOLD_EMPTY;
        end else begin
          state_d = HOLD_FULL;
        end
      end
      default: begin
        state_d = HOLD_EMPTY;
        frame_d = {FRAME_W{1'b0}};
      end
    endcase
  end

  assign out_valid = (state_q == HOLD_FULL);
  assign stall     = out_valid && !out_ready;
  assign lane_1    = frame_q[0*SYM_W +: SYM_W];
  assign lane_2    = frame_q[1*SYM_W +: SYM_W];
  assign lane_3    = frame_q[2*SYM_W +: SYM_W];
  assign lane_4    = frame_q[3*SYM_W +: SYM_W];

endmodule

// File: rtl/sym_frame_deserializer.sv
// Groups a valid/ready stream of 2-bit symbols into 4-lane frames, with
// start-of-frame resync and a saturating count of discarded partial frames.
module sym_frame_deserializer
  import sym_frame_deserializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYM_W-1:0]  in_sym,
  input  logic              in_sof,
  output logic [SYM_W-1:0]  data_1,
  output logic [SYM_W-1:0]  data_2,
  output logic [SYM_W-1:0]  data_3,
  output logic [SYM_W-1:0]  data_4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               accept_s;
  logic               load_s;
  logic               hold_stall_s;
  logic [FRAME_W-1:0] frame_s;

  // Only the last beat needs the holding register; earlier beats always have a slot
  assign in_ready = !((cnt_q == BEAT_LAST) && hold_stall_s);
  assign accept_s = in_valid && in_ready;
  assign frame_s  = {in_sym, acc_q};
  assign drop_cnt = drop_q;

  // Beat counter, accumulator and drop counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= BEAT_FIRST;
      acc_q  <= {ACC_W{1'b0}};
      drop_q <= {DROP_W{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end

  // Fill control: sof restarts at beat 0, beat 3 completes straight into the hold register
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    drop_d = drop_q;
    load_s = 1'b0;
    if (accept_s) begin
      if (in_sof) begin
        acc_d[0 +: SYM_W] = in_sym;
        cnt_d             = CNT_W'(1);
        if (cnt_q != BEAT_FIRST) begin
          drop_d = sat_inc(drop_q);
        end else begin
          drop_d = drop_q;
        end
      end else if (cnt_q == BEAT_LAST) begin
        load_s = 1'b1;
        cnt_d  = BEAT_FIRST;
      end else begin
        case (cnt_q)
          2'd0:    acc_d[0*SYM_W +: SYM_W] = in_sym;
          2'd1:    acc_d[1*SYM_W +: SYM_W] = in_sym;
          2'd2:    acc_d[2*SYM_W +: SYM_W] = in_sym;
          default: acc_d = acc_q;
        endcase
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      load_s = 1'b0;
    end
  end

  frame_hold_reg u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .frame_in  (frame_s),
    .out_ready (out_ready),
    .lane_1    (data_1),
    .lane_2    (data_2),
    .lane_3    (data_3),
    .lane_4    (data_4),
    .out_valid (out_valid),
    .stall     (hold_stall_s)
  );

endmodule
